// File: rtl/sev_seg_pkg.sv
// rtl/sev_seg_pkg.sv - shared types and helpers for the seven-segment digit multiplexer
//
// Contents:
//   state_t      multiplexer sequencing states
//   NIBBLE_W     width of one hex digit on the shared segment bus
//   idx_width()  index width for n items, never below one bit
package sev_seg_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BLANK,
    S_SHOW
  } state_t;

  localparam int NIBBLE_W = 4;

  // $clog2(1) is 0, which would leave a zero-width index for one digit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sev_seg_dwell.sv
// rtl/sev_seg_dwell.sv - loadable down-counter timing the blank and hold intervals
//
// Ports:
//   clk       system clock, rising edge
//   reset_n   asynchronous active-low reset, clears the count
//   load      load load_val this clock (has priority over counting)
//   load_val  remaining clocks minus one for the interval being started
//   cnt       current remaining count
//   done      count has reached zero, i.e. this is the last clock of the interval
module sev_seg_dwell #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/sev_seg_mux.sv
// rtl/sev_seg_mux.sv - time-multiplexes NUM_DIGITS hex nibbles onto one segment bus
//
// Optional build macro: SEV_SEG_DIM_EN adds the duty_i brightness input.
//
// Ports:
//   clk           system clock, rising edge
//   reset_n       asynchronous active-low reset
//   en            multiplex enable; low returns to idle with all selects off
//   digits_i      nibble k at bits [4k+3:4k], captured once per frame
//   blank_mask_i  1 = digit k is never selected (sampled every clock)
//   duty_i        on-time in clocks per dwell (SEV_SEG_DIM_EN only)
//   digit_sel     one-hot-or-zero digit select, active high
//   sw            nibble of the currently indexed digit
//   digit_idx     current digit index
//   frame_done    one-clock pulse with the last clock of the last digit's dwell
//
// Every output is a register fed from the current sequencing state, so the
// outputs trail the state machine by one clock: en seen in S_IDLE at edge N
// gives the first select at edge N+1+BLANK_CYCLES.
module sev_seg_mux
  import sev_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 2,
  parameter int HOLD_CYCLES  = 4,
  parameter int BLANK_CYCLES = 1,
  parameter int DUTY_W       = 4
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               en,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0]     digits_i,
  input  logic [NUM_DIGITS-1:0]              blank_mask_i,
`ifdef SEV_SEG_DIM_EN
  input  logic [DUTY_W-1:0]                  duty_i,
`endif
  output logic [NUM_DIGITS-1:0]              digit_sel,
  output logic [NIBBLE_W-1:0]                sw,
  output logic [idx_width(NUM_DIGITS)-1:0]   digit_idx,
  output logic                               frame_done
);

  localparam int IDX_W   = idx_width(NUM_DIGITS);
  localparam int MAX_CYC = (HOLD_CYCLES > BLANK_CYCLES) ? HOLD_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = idx_width(MAX_CYC + 1);
  localparam int CMP_W   = (DUTY_W > CNT_W) ? DUTY_W : CNT_W;

  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LD = (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;

  // With no dead time every dwell starts straight in S_SHOW.
  localparam state_t           FIRST_ST = (BLANK_CYCLES > 0) ? S_BLANK : S_SHOW;
  localparam logic [CNT_W-1:0] FIRST_LD = (BLANK_CYCLES > 0) ? BLANK_LD : HOLD_LD;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  state_t                         state_r, state_n;
  logic [IDX_W-1:0]               idx_r, idx_n;
  logic [NIBBLE_W*NUM_DIGITS-1:0] snap_r, snap_n;
  logic                           cnt_load;
  logic [CNT_W-1:0]               cnt_load_val;
  logic [CNT_W-1:0]               cnt;
  logic                           cnt_done;
  logic                           frame_pulse;

  logic [NIBBLE_W-1:0]            cur_nib;
  logic [NUM_DIGITS-1:0]          sel_vec;
  logic [CMP_W-1:0]               elapsed;
  logic [CMP_W-1:0]               duty_ext;
  logic                           show_on;

  sev_seg_dwell #(
    .CNT_W (CNT_W)
  ) u_dwell (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .cnt      (cnt),
    .done     (cnt_done)
  );

  // ---------------------------------------------------------------------------
  // Sequencing state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= S_IDLE;
      idx_r   <= '0;
      snap_r  <= '0;
    end else begin
      state_r <= state_n;
      idx_r   <= idx_n;
      snap_r  <= snap_n;
    end
  end

  always_comb begin
    state_n      = state_r;
    idx_n        = idx_r;
    snap_n       = snap_r;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    frame_pulse  = 1'b0;

    unique case (state_r)
      S_IDLE: begin
        idx_n = '0;
        if (en) begin
          snap_n       = digits_i;
          state_n      = FIRST_ST;
          cnt_load     = 1'b1;
          cnt_load_val = FIRST_LD;
        end
      end

      S_BLANK: begin
        if (!en) begin
          state_n  = S_IDLE;
          idx_n    = '0;
          cnt_load = 1'b1;
        end else if (cnt_done) begin
          state_n      = S_SHOW;
          cnt_load     = 1'b1;
          cnt_load_val = HOLD_LD;
        end
      end

      S_SHOW: begin
        if (!en) begin
          state_n  = S_IDLE;
          idx_n    = '0;
          cnt_load = 1'b1;
        end else if (cnt_done) begin
          state_n      = FIRST_ST;
          cnt_load     = 1'b1;
          cnt_load_val = FIRST_LD;
          if (idx_r == LAST_IDX) begin
            // Frame boundary: the only point the displayed data may change.
            idx_n       = '0;
            snap_n      = digits_i;
            frame_pulse = 1'b1;
          end else begin
            idx_n = idx_r + IDX_W'(1);
          end
        end
      end

      default: begin
        state_n  = S_IDLE;
        idx_n    = '0;
        cnt_load = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output data path
  // ---------------------------------------------------------------------------
  always_comb begin
    cur_nib = '0;
    sel_vec = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_r == IDX_W'(k)) begin
        cur_nib    = snap_r[k*NIBBLE_W +: NIBBLE_W];
        sel_vec[k] = ~blank_mask_i[k];
      end
    end
  end

  // Clocks already spent in the current dwell; the counter runs downwards.
  assign elapsed = CMP_W'(HOLD_LD) - CMP_W'(cnt);

`ifdef SEV_SEG_DIM_EN
  assign duty_ext = CMP_W'(duty_i);
`else
  // Without dimming the on-time is the whole dwell.
  assign duty_ext = CMP_W'(HOLD_CYCLES);
`endif

  assign show_on = (elapsed < duty_ext);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digit_sel  <= '0;
      sw         <= '0;
      digit_idx  <= '0;
      frame_done <= 1'b0;
    end else begin
      // Gating on en drops the selects on the same edge the FSM goes idle.
      if (en && (state_r == S_SHOW) && show_on) begin
        digit_sel <= sel_vec;
      end else begin
        digit_sel <= '0;
      end
      sw         <= cur_nib;
      digit_idx  <= en ? idx_r : '0;
      frame_done <= frame_pulse;
    end
  end

endmodule

// File: tb/tb_sev_seg_mux.sv
// tb/tb_sev_seg_mux.sv - scoreboard bench for sev_seg_mux
module tb_sev_seg_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n = 1'b0;

  // DUT A: 2 digits, hold 4, blank 1
  logic        en_a;
  logic [7:0]  dig_a;
  logic [1:0]  mask_a;
  logic [1:0]  a_sel;
  logic [3:0]  a_sw;
  logic [0:0]  a_idx;
  logic        a_fd;

  // DUT B: 4 digits, hold 1, blank 0
  logic        en_b;
  logic [15:0] dig_b;
  logic [3:0]  mask_b;
  logic [3:0]  b_sel;
  logic [3:0]  b_sw;
  logic [1:0]  b_idx;
  logic        b_fd;

`ifdef SEV_SEG_DIM_EN
  logic        en_c;
  logic [7:0]  dig_c;
  logic [1:0]  mask_c;
  logic [3:0]  duty_c;
  logic [1:0]  c_sel;
  logic [3:0]  c_sw;
  logic [0:0]  c_idx;
  logic        c_fd;
  logic [3:0]  duty_full = 4'd15;
`endif

  sev_seg_mux #(.NUM_DIGITS(2), .HOLD_CYCLES(4), .BLANK_CYCLES(1), .DUTY_W(4)) dut_a (
    .clk          (clk),
    .reset_n      (reset_n),
    .en           (en_a),
    .digits_i     (dig_a),
    .blank_mask_i (mask_a),
`ifdef SEV_SEG_DIM_EN
    .duty_i       (duty_full),
`endif
    .digit_sel    (a_sel),
    .sw           (a_sw),
    .digit_idx    (a_idx),
    .frame_done   (a_fd)
  );

  sev_seg_mux #(.NUM_DIGITS(4), .HOLD_CYCLES(1), .BLANK_CYCLES(0), .DUTY_W(4)) dut_b (
    .clk          (clk),
    .reset_n      (reset_n),
    .en           (en_b),
    .digits_i     (dig_b),
    .blank_mask_i (mask_b),
`ifdef SEV_SEG_DIM_EN
    .duty_i       (duty_full),
`endif
    .digit_sel    (b_sel),
    .sw           (b_sw),
    .digit_idx    (b_idx),
    .frame_done   (b_fd)
  );

`ifdef SEV_SEG_DIM_EN
  sev_seg_mux #(.NUM_DIGITS(2), .HOLD_CYCLES(4), .BLANK_CYCLES(1), .DUTY_W(4)) dut_c (
    .clk          (clk),
    .reset_n      (reset_n),
    .en           (en_c),
    .digits_i     (dig_c),
    .blank_mask_i (mask_c),
    .duty_i       (duty_c),
    .digit_sel    (c_sel),
    .sw           (c_sw),
    .digit_idx    (c_idx),
    .frame_done   (c_fd)
  );
`endif

  typedef struct packed {
    logic [7:0] sel;
    logic [3:0] sw;
    logic [2:0] idx;
    logic       fd;
  } vec_t;

  vec_t qa[$];
  vec_t qb[$];
  vec_t qc[$];

  int errors = 0;
  int checks = 0;

  function automatic vec_t mk(input logic [7:0] sel, input logic [3:0] sw,
                              input logic [2:0] idx, input logic fd);
    vec_t v;
    v.sel = sel;
    v.sw  = sw;
    v.idx = idx;
    v.fd  = fd;
    return v;
  endfunction

  task automatic cmp(input string name, input int cyc, input vec_t got, input vec_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got sel=%b sw=%h idx=%0d done=%b, expected sel=%b sw=%h idx=%0d done=%b",
               name, cyc, got.sel, got.sw, got.idx, got.fd, exp.sel, exp.sw, exp.idx, exp.fd);
    end
  endtask

  task automatic push(input int q, input int n, input vec_t v);
    for (int i = 0; i < n; i++) begin
      case (q)
        0:       qa.push_back(v);
        1:       qb.push_back(v);
        default: qc.push_back(v);
      endcase
    end
  endtask

  // One 10-clock frame of a 2-digit, hold-4, blank-1 instance:
  // blank, 4 show clocks of digit 0, blank, 4 show clocks of digit 1.
  task automatic push_frame2(input int q, input logic [3:0] n0, input logic [3:0] n1,
                             input logic [1:0] mask, input int duty);
    push(q, 1, mk(8'd0, n0, 3'd0, 1'b0));
    for (int k = 0; k < 4; k++)
      push(q, 1, mk((k < duty && !mask[0]) ? 8'd1 : 8'd0, n0, 3'd0, 1'b0));
    push(q, 1, mk(8'd0, n1, 3'd1, 1'b0));
    for (int k = 0; k < 4; k++)
      push(q, 1, mk((k < duty && !mask[1]) ? 8'd2 : 8'd0, n1, 3'd1, k == 3));
  endtask

  // Monitors: one expected vector per clock while the scoreboard holds any.
  initial begin
    int n;
    vec_t e;
    n = 0;
    forever begin
      @(posedge clk);
      #2;
      if (qa.size() > 0) begin
        n++;
        e = qa.pop_front();
        cmp("dut_a", n, mk({6'd0, a_sel}, a_sw, {2'd0, a_idx}, a_fd), e);
      end
    end
  end

  initial begin
    int n;
    vec_t e;
    n = 0;
    forever begin
      @(posedge clk);
      #2;
      if (qb.size() > 0) begin
        n++;
        e = qb.pop_front();
        cmp("dut_b", n, mk({4'd0, b_sel}, b_sw, {1'b0, b_idx}, b_fd), e);
      end
    end
  end

`ifdef SEV_SEG_DIM_EN
  initial begin
    int n;
    vec_t e;
    n = 0;
    forever begin
      @(posedge clk);
      #2;
      if (qc.size() > 0) begin
        n++;
        e = qc.pop_front();
        cmp("dut_c", n, mk({6'd0, c_sel}, c_sw, {2'd0, c_idx}, c_fd), e);
      end
    end
  end
`endif

  initial begin
    en_a   = 1'b1;
    dig_a  = 8'hA5;
    mask_a = 2'b00;
    en_b   = 1'b1;
    dig_b  = 16'h4321;
    mask_b = 4'b0000;
`ifdef SEV_SEG_DIM_EN
    en_c   = 1'b1;
    dig_c  = 8'hA5;
    mask_c = 2'b00;
    duty_c = 4'd2;
`endif

    @(negedge clk);
    cmp("reset_a", 0, mk({6'd0, a_sel}, a_sw, {2'd0, a_idx}, a_fd), mk(8'd0, 4'd0, 3'd0, 1'b0));
    cmp("reset_b", 0, mk({4'd0, b_sel}, b_sw, {1'b0, b_idx}, b_fd), mk(8'd0, 4'd0, 3'd0, 1'b0));
    reset_n = 1'b1;

    // A: idle clock, then two frames of 5/A.
    push(0, 1, mk(8'd0, 4'h0, 3'd0, 1'b0));
    push_frame2(0, 4'h5, 4'hA, 2'b00, 4);
    push_frame2(0, 4'h5, 4'hA, 2'b00, 4);

    // B: idle clock, then three 4-clock frames of 1,2,3,4.
    push(1, 1, mk(8'd0, 4'h0, 3'd0, 1'b0));
    for (int f = 0; f < 3; f++) begin
      push(1, 1, mk(8'b0001, 4'h1, 3'd0, 1'b0));
      push(1, 1, mk(8'b0010, 4'h2, 3'd1, 1'b0));
      push(1, 1, mk(8'b0100, 4'h3, 3'd2, 1'b0));
      push(1, 1, mk(8'b1000, 4'h4, 3'd3, 1'b1));
    end

`ifdef SEV_SEG_DIM_EN
    push(2, 1, mk(8'd0, 4'h0, 3'd0, 1'b0));
    push_frame2(2, 4'h5, 4'hA, 2'b00, 2);
    push_frame2(2, 4'h5, 4'hA, 2'b00, 2);
`endif

    for (int cyc = 1; cyc <= 70; cyc++) begin
      @(negedge clk);
      case (cyc)
        13: begin
          // Mid-frame data change must wait for the next frame.
          dig_a = 8'h3C;
          push_frame2(0, 4'hC, 4'h3, 2'b00, 4);
        end
        21: begin
`ifdef SEV_SEG_DIM_EN
          duty_c = 4'd0;
          push_frame2(2, 4'h5, 4'hA, 2'b00, 0);
`endif
        end
        31: begin
          mask_a = 2'b10;
          push_frame2(0, 4'hC, 4'h3, 2'b10, 4);
`ifdef SEV_SEG_DIM_EN
          duty_c = 4'd7;
          push_frame2(2, 4'h5, 4'hA, 2'b00, 7);
`endif
        end
        41: begin
          mask_a = 2'b00;
          push(0, 1, mk(8'd0, 4'hC, 3'd0, 1'b0));
          push(0, 4, mk(8'd1, 4'hC, 3'd0, 1'b0));
          push(0, 1, mk(8'd0, 4'h3, 3'd1, 1'b0));
          push(0, 2, mk(8'd2, 4'h3, 3'd1, 1'b0));
        end
        49: begin
          // Abort in the middle of digit 1's dwell.
          en_a = 1'b0;
          push(0, 1, mk(8'd0, 4'h3, 3'd0, 1'b0));
          push(0, 2, mk(8'd0, 4'hC, 3'd0, 1'b0));
        end
        52: begin
          en_a = 1'b1;
          push(0, 1, mk(8'd0, 4'hC, 3'd0, 1'b0));
          push_frame2(0, 4'hC, 4'h3, 2'b00, 4);
        end
        default: ;
      endcase
    end

    checks++;
    if (qa.size() != 0) begin
      errors++;
      $display("FAIL drain_a: %0d expected vectors left, expected 0", qa.size());
    end
    checks++;
    if (qb.size() != 0) begin
      errors++;
      $display("FAIL drain_b: %0d expected vectors left, expected 0", qb.size());
    end
    checks++;
    if (qc.size() != 0) begin
      errors++;
      $display("FAIL drain_c: %0d expected vectors left, expected 0", qc.size());
    end

    // Asynchronous reset between clock edges while digit 1 of A is shown.
    #2;
    reset_n = 1'b0;
    #1;
    cmp("async_reset_a", 0, mk({6'd0, a_sel}, a_sw, {2'd0, a_idx}, a_fd), mk(8'd0, 4'd0, 3'd0, 1'b0));
    cmp("async_reset_b", 0, mk({4'd0, b_sel}, b_sw, {1'b0, b_idx}, b_fd), mk(8'd0, 4'd0, 3'd0, 1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
